// File: rtl/mcpu6_core.sv
// Parametrised 6-bit-instruction accumulator CPU core: single-cycle execution of the
// externally fed instruction stream, with a register file, a circular return stack and an OUT port.
module mcpu6_core #(
    parameter int DW     = 8,
    parameter int PCW    = 8,
    parameter int NREG   = 8,
    parameter int SDEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [5:0]     inst_in,
    output logic [PCW-1:0] pc_out,
    output logic [DW-1:0]  accu_out,
    output logic           carry_out,
    output logic [DW-1:0]  out_port,
    output logic           out_valid,
    output logic           stack_err
);
    localparam int NMAX = DW / 4 - 1;
    localparam int NW   = (NMAX > 1) ? $clog2(NMAX + 1) : 1;
    localparam int RW   = $clog2(NREG);
    localparam int SW   = $clog2(SDEPTH + 1);
    localparam int TW   = (SDEPTH > 1) ? $clog2(SDEPTH) : 1;
    localparam logic [NW-1:0] NIB_MAX = NW'(NMAX);
    localparam logic [SW-1:0] SP_FULL = SW'(SDEPTH);
    localparam logic [TW-1:0] TP_LAST = TW'(SDEPTH - 1);

    typedef enum logic [3:0] {
        OP_BCC, OP_LDI, OP_ADD, OP_STA, OP_LDA, OP_NOT, OP_NEG,
        OP_JSR, OP_OUT, OP_RET, OP_RCR, OP_CLC, OP_NOP
    } op_t;

    logic [PCW-1:0] pc, pc_n;
    logic [DW-1:0]  accu, accu_n, oreg_n, rd;
    logic           carry, carry_n, ov_n, err_n, reg_we, push;
    logic [NW-1:0]  nib, nib_n;
    logic [SW-1:0]  sp, sp_n;
    logic [TW-1:0]  tp, tp_n, tp_inc, tp_dec;
    logic signed [DW-1:0] imm;
    op_t            op;

    logic [DW-1:0]  regs [NREG];
    logic [PCW-1:0] stk  [SDEPTH];

    function automatic op_t decode(input logic [5:0] i);
        op_t o;
        casez (i)
            6'b00????: o = OP_BCC;
            6'b01????: o = OP_LDI;
            6'b100???: o = OP_ADD;
            6'b101???: o = OP_STA;
            6'b110???: o = OP_LDA;
            6'b11100?: o = i[0] ? OP_NEG : OP_NOT;
            6'b111010: o = OP_JSR;
            6'b111011: o = OP_OUT;
            6'b111100: o = OP_RET;
            6'b111101: o = OP_RCR;
            6'b111110: o = OP_CLC;
            default:   o = OP_NOP;
        endcase
        return o;
    endfunction

    // Sign-extended nibble on top of the nibbles already collected by the preceding LDIs.
    function automatic logic signed [DW-1:0] build_imm(input logic [3:0] i4,
                                                       input logic [DW-1:0] a,
                                                       input logic [NW-1:0] n);
        logic signed [DW-1:0] sx;
        logic [DW-1:0]        keep;
        sx   = {{(DW-4){i4[3]}}, i4};
        keep = '0;
        for (int b = 0; b < DW; b++) keep[b] = (b < 4 * int'(n));
        return signed'((sx << (4 * int'(n))) | (a & keep));
    endfunction

    function automatic logic [PCW-1:0] imm_to_pc(input logic signed [DW-1:0] v);
        return PCW'(v);
    endfunction

    function automatic logic [NW-1:0] sat_nib(input logic [NW-1:0] n);
        return (n == NIB_MAX) ? n : n + 1'b1;
    endfunction

    assign rd     = regs[inst_in[RW-1:0]];
    assign tp_inc = (tp == TP_LAST) ? '0 : tp + 1'b1;
    assign tp_dec = (tp == '0) ? TP_LAST : tp - 1'b1;

    always_comb begin
        op      = decode(inst_in);
        imm     = build_imm(inst_in[3:0], accu, nib);
        pc_n    = pc + 1'b1;
        accu_n  = accu;
        carry_n = carry;
        nib_n   = '0;
        sp_n    = sp;
        tp_n    = tp;
        oreg_n  = out_port;
        ov_n    = 1'b0;
        err_n   = stack_err;
        reg_we  = 1'b0;
        push    = 1'b0;
        unique case (op)
            OP_BCC: begin
                if (!carry) pc_n = pc + imm_to_pc(imm);
                carry_n = 1'b0;
            end
            OP_LDI: begin
                accu_n = imm;
                nib_n  = sat_nib(nib);
            end
            OP_ADD: {carry_n, accu_n} = {1'b0, rd} + {1'b0, accu};
            OP_STA: reg_we = 1'b1;
            OP_LDA: accu_n = rd;
            OP_NOT: accu_n = ~accu;
            OP_NEG: {carry_n, accu_n} = {1'b0, ~accu} + 1'b1;
            OP_JSR: begin
                // A full stack overwrites its oldest entry, which is where tp already points.
                push = 1'b1;
                tp_n = tp_inc;
                pc_n = PCW'(accu);
                if (sp == SP_FULL) err_n = 1'b1;
                else               sp_n  = sp + 1'b1;
            end
            OP_OUT: begin
                oreg_n = accu;
                ov_n   = 1'b1;
            end
            OP_RET: begin
                if (sp == '0) begin
                    err_n = 1'b1;
                end else begin
                    pc_n = stk[tp_dec];
                    tp_n = tp_dec;
                    sp_n = sp - 1'b1;
                end
            end
            OP_RCR: {accu_n, carry_n} = {carry, accu};
            OP_CLC: carry_n = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= '0;
            accu      <= '0;
            carry     <= 1'b0;
            nib       <= '0;
            sp        <= '0;
            tp        <= '0;
            out_port  <= '0;
            out_valid <= 1'b0;
            stack_err <= 1'b0;
        end else begin
            pc        <= pc_n;
            accu      <= accu_n;
            carry     <= carry_n;
            nib       <= nib_n;
            sp        <= sp_n;
            tp        <= tp_n;
            out_port  <= oreg_n;
            out_valid <= ov_n;
            stack_err <= err_n;
        end
    end

    // Storage arrays are not reset; writes are only suppressed while rst is high.
    always_ff @(posedge clk) begin
        if (!rst && reg_we) regs[inst_in[RW-1:0]] <= accu;
        if (!rst && push)   stk[tp] <= pc + 1'b1;
    end

    assign pc_out    = pc;
    assign accu_out  = accu;
    assign carry_out = carry;
endmodule

// File: tb/tb_mcpu6_core.sv
// Directed bench for mcpu6_core: an 8-bit default instance and a 16-bit/12-bit-PC/4-register instance.
module tb_mcpu6_core;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, rst16 = 1'b1;
    logic [5:0]  inst = 6'h3F, inst16 = 6'h3F;
    logic [7:0]  pc8, acc8, op8;
    logic        c8, ov8, se8;
    logic [11:0] pc16;
    logic [15:0] acc16, op16;
    logic        c16, ov16, se16;

    int total = 0;
    int bad   = 0;

    localparam logic [5:0] NOT_ = 6'b111000, NEG = 6'b111001, JSR = 6'b111010, OUT = 6'b111011;
    localparam logic [5:0] RET  = 6'b111100, RCR = 6'b111101, CLC = 6'b111110, NOP = 6'b111111;

    typedef struct {
        string       tag;
        bit          wide;
        logic [31:0] pc;
        logic [31:0] accu;
        logic        carry;
    } exp_t;
    exp_t sb[$];

    mcpu6_core u8 (
        .clk(clk), .rst(rst), .inst_in(inst), .pc_out(pc8), .accu_out(acc8),
        .carry_out(c8), .out_port(op8), .out_valid(ov8), .stack_err(se8)
    );

    mcpu6_core #(.DW(16), .PCW(12), .NREG(4), .SDEPTH(4)) u16 (
        .clk(clk), .rst(rst16), .inst_in(inst16), .pc_out(pc16), .accu_out(acc16),
        .carry_out(c16), .out_port(op16), .out_valid(ov16), .stack_err(se16)
    );

    function automatic logic [5:0] ldi(input logic [3:0] i); return {2'b01, i}; endfunction
    function automatic logic [5:0] bcc(input logic [3:0] i); return {2'b00, i}; endfunction
    function automatic logic [5:0] add(input logic [2:0] r); return {3'b100, r}; endfunction
    function automatic logic [5:0] sta(input logic [2:0] r); return {3'b101, r}; endfunction
    function automatic logic [5:0] lda(input logic [2:0] r); return {3'b110, r}; endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step(input bit wide, input logic [5:0] ins, input string tag,
                        input logic [31:0] epc, input logic [31:0] eacc, input logic ec);
        exp_t e;
        if (wide) inst16 = ins;
        else      inst   = ins;
        sb.push_back('{tag, wide, epc, eacc, ec});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        if (e.wide) begin
            chk({e.tag, ".pc"},    32'(pc16),  e.pc);
            chk({e.tag, ".accu"},  32'(acc16), e.accu);
            chk({e.tag, ".carry"}, 32'(c16),   32'(e.carry));
        end else begin
            chk({e.tag, ".pc"},    32'(pc8),  e.pc);
            chk({e.tag, ".accu"},  32'(acc8), e.accu);
            chk({e.tag, ".carry"}, 32'(c8),   32'(e.carry));
        end
    endtask

    task automatic s8(input logic [5:0] ins, input string tag,
                      input logic [31:0] epc, input logic [31:0] eacc, input logic ec);
        step(1'b0, ins, tag, epc, eacc, ec);
    endtask

    task automatic s16(input logic [5:0] ins, input string tag,
                       input logic [31:0] epc, input logic [31:0] eacc, input logic ec);
        step(1'b1, ins, tag, epc, eacc, ec);
    endtask

    task automatic do_rst(input bit wide, input logic [5:0] hold);
        if (wide) begin rst16 = 1'b1; inst16 = hold; end
        else      begin rst   = 1'b1; inst   = hold; end
        @(posedge clk);
        #1;
        if (wide) begin
            rst16 = 1'b0;
            chk("rst16.pc", 32'(pc16), 0);
            chk("rst16.accu", 32'(acc16), 0);
            chk("rst16.carry", 32'(c16), 0);
            chk("rst16.stack_err", 32'(se16), 0);
        end else begin
            rst = 1'b0;
            chk("rst.pc", 32'(pc8), 0);
            chk("rst.accu", 32'(acc8), 0);
            chk("rst.carry", 32'(c8), 0);
            chk("rst.out_port", 32'(op8), 0);
            chk("rst.out_valid", 32'(ov8), 0);
            chk("rst.stack_err", 32'(se8), 0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        do_rst(1'b0, NOP);

        // immediate chaining and nibble saturation
        s8(ldi(4'hA), "ldi_a",  'h01, 'hFA, 0);
        s8(ldi(4'h5), "ldi_5",  'h02, 'h5A, 0);
        s8(ldi(4'h3), "nibsat", 'h03, 'h3A, 0);
        s8(NOP,       "nop",    'h04, 'h3A, 0);

        // add with carry-out, conditional branch, register file
        s8(ldi(4'hF), "ldi_f",   'h05, 'hFF, 0);
        s8(sta(3'd3), "sta3",    'h06, 'hFF, 0);
        s8(ldi(4'h1), "ldi_1",   'h07, 'h01, 0);
        s8(add(3'd3), "add_cy",  'h08, 'h00, 1);
        s8(bcc(4'h3), "bcc_nt",  'h09, 'h00, 0);
        s8(bcc(4'h3), "bcc_tk",  'h0C, 'h00, 0);
        s8(lda(3'd3), "lda3",    'h0D, 'hFF, 0);
        s8(ldi(4'h7), "ldi_7",   'h0E, 'h07, 0);
        s8(sta(3'd2), "sta2",    'h0F, 'h07, 0);
        s8(lda(3'd2), "sta_lda", 'h10, 'h07, 0);
        s8(NOT_,      "not",     'h11, 'hF8, 0);
        s8(lda(3'd2), "lda2",    'h12, 'h07, 0);
        s8(bcc(4'hE), "bcc_neg", 'h10, 'h07, 0);
        s8(ldi(4'h4), "ldi_4",   'h11, 'h04, 0);
        s8(bcc(4'h0), "bcc_ext", 'h15, 'h04, 0);

        // subroutine call/return and underflow
        s8(ldi(4'h4), "t3_ldi4", 'h16, 'h04, 0);
        s8(ldi(4'h1), "t3_ldi1", 'h17, 'h14, 0);
        s8(JSR,       "t3_jsr",  'h14, 'h14, 0);
        chk("t3_jsr.err", 32'(se8), 0);
        s8(RET,       "t3_ret",  'h18, 'h14, 0);
        chk("t3_ret.err", 32'(se8), 0);
        s8(RET,       "t3_uf",   'h19, 'h14, 0);
        chk("t3_uf.err", 32'(se8), 1);

        // reset in the middle of an LDI chain with a live stack entry
        s8(ldi(4'h2), "pre_ldi", 'h1A, 'h02, 0);
        s8(JSR,       "pre_jsr", 'h02, 'h02, 0);
        do_rst(1'b0, ldi(4'h6));
        s8(ldi(4'h9), "post_ldi", 'h01, 'hF9, 0);
        s8(RET,       "post_ret", 'h02, 'hF9, 0);
        chk("post_ret.err", 32'(se8), 1);
        do_rst(1'b0, NOP);

        // overflow: five calls, oldest return address dropped
        s8(ldi(4'h3), "ov_l1", 'h01, 'h03, 0);
        s8(JSR,       "ov_j1", 'h03, 'h03, 0);
        s8(ldi(4'h6), "ov_l2", 'h04, 'h06, 0);
        s8(JSR,       "ov_j2", 'h06, 'h06, 0);
        s8(ldi(4'h9), "ov_l3", 'h07, 'hF9, 0);
        s8(JSR,       "ov_j3", 'hF9, 'hF9, 0);
        s8(ldi(4'h2), "ov_l4", 'hFA, 'h02, 0);
        s8(JSR,       "ov_j4", 'h02, 'h02, 0);
        chk("ov_j4.err", 32'(se8), 0);
        s8(ldi(4'h5), "ov_l5", 'h03, 'h05, 0);
        s8(JSR,       "ov_j5", 'h05, 'h05, 0);
        chk("ov_j5.err", 32'(se8), 1);
        s8(RET, "ov_r1", 'h04, 'h05, 0);
        s8(RET, "ov_r2", 'hFB, 'h05, 0);
        s8(RET, "ov_r3", 'h08, 'h05, 0);
        s8(RET, "ov_r4", 'h05, 'h05, 0);
        s8(RET, "ov_r5", 'h06, 'h05, 0);

        // rotate, output pulse, negate
        s8(CLC,       "clc",    'h07, 'h05, 0);
        s8(ldi(4'hE), "r_ldie", 'h08, 'hFE, 0);
        s8(ldi(4'h7), "r_ldi7", 'h09, 'h7E, 0);
        s8(NOT_,      "r_not",  'h0A, 'h81, 0);
        s8(RCR,       "rcr",    'h0B, 'h40, 1);
        chk("pre_out.valid", 32'(ov8), 0);
        s8(OUT,       "out",    'h0C, 'h40, 1);
        chk("out.valid", 32'(ov8), 1);
        chk("out.port", 32'(op8), 'h40);
        s8(NOP,       "out_nop", 'h0D, 'h40, 1);
        chk("out_nop.valid", 32'(ov8), 0);
        chk("out_nop.port", 32'(op8), 'h40);
        s8(NEG,       "neg40",  'h0E, 'hC0, 0);
        s8(ldi(4'h0), "ldi0",   'h0F, 'h00, 0);
        s8(NEG,       "neg0",   'h10, 'h00, 1);
        s8(RCR,       "rcr_c",  'h11, 'h80, 0);
        s8(add(3'd2), "add_nc", 'h12, 'h87, 0);
        inst = NOP;

        // wide instance: four-nibble immediates, register aliasing, PC truncation
        do_rst(1'b1, NOP);
        s16(ldi(4'h1), "w_l1",   'h001, 'h0001, 0);
        s16(ldi(4'h2), "w_l2",   'h002, 'h0021, 0);
        s16(ldi(4'h3), "w_l3",   'h003, 'h0321, 0);
        s16(ldi(4'h4), "w_l4",   'h004, 'h4321, 0);
        s16(ldi(4'h5), "w_sat",  'h005, 'h5321, 0);
        s16(sta(3'd5), "w_sta5", 'h006, 'h5321, 0);
        s16(ldi(4'h0), "w_l0",   'h007, 'h0000, 0);
        s16(lda(3'd1), "w_lda1", 'h008, 'h5321, 0);
        s16(JSR,       "w_jsr",  'h321, 'h5321, 0);
        s16(RET,       "w_ret",  'h009, 'h5321, 0);
        s16(ldi(4'h0), "w_l0b",  'h00A, 'h0000, 0);
        s16(NEG,       "w_neg0", 'h00B, 'h0000, 1);
        s16(CLC,       "w_clc",  'h00C, 'h0000, 0);
        s16(bcc(4'hC), "w_bcc",  'h008, 'h0000, 0);
        chk("w.err", 32'(se16), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
